// File: rtl/combine_rr_pkg.sv
// ============================================================================
//  Module   : combine_pkg
//  Purpose  : Shared types and helpers for the round-robin memory combiner.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package combine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Port-index width; a single-port build still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/combine_rr_arbiter.sv
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick, searching from last_grant+1.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx
);

    always_comb begin
        int   cand;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = (int'(last_grant) + k) % NUM_PORTS;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/combine_rr.sv
// ============================================================================
//  Module   : combine_rr
//  Purpose  : N-port memory combiner with per-port address windows and
//             round-robin arbitration. Optional window check: COMBINE_BOUNDS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module combine_rr #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int WORD_WIDTH = 64,
    parameter int OFFSET     = 128
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
    output logic [NUM_PORTS*WORD_WIDTH-1:0] din,
    input  logic [NUM_PORTS*WORD_WIDTH-1:0] dout,
    input  logic [NUM_PORTS-1:0]            re,
    input  logic [NUM_PORTS-1:0]            we,
    output logic [NUM_PORTS-1:0]            ready,
    output logic [NUM_PORTS-1:0]            err,
    output logic [ADDR_WIDTH-1:0]           maddr,
    output logic [WORD_WIDTH-1:0]           mout,
    input  logic [WORD_WIDTH-1:0]           min,
    output logic                            mre,
    output logic                            mwe,
    input  logic                            mready
);

    import combine_pkg::*;

    localparam int c_idx_w = idx_width(NUM_PORTS);

    state_t                          r_state;
    logic [c_idx_w-1:0]              r_last_grant;
    logic [c_idx_w-1:0]              r_idx;
    logic [ADDR_WIDTH-1:0]           r_maddr;
    logic [WORD_WIDTH-1:0]           r_mout;
    logic                            r_mre;
    logic                            r_mwe;
    logic [NUM_PORTS-1:0]            r_ready;
    logic [NUM_PORTS*WORD_WIDTH-1:0] r_din;
`ifdef COMBINE_BOUNDS_EN
    logic [NUM_PORTS-1:0]            r_err;
`endif

    logic [NUM_PORTS-1:0]  w_req;
    logic [NUM_PORTS-1:0]  w_gnt;
    logic [c_idx_w-1:0]    w_gnt_idx;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [ADDR_WIDTH-1:0] w_reloc_addr;
    logic [WORD_WIDTH-1:0] w_sel_dout;
    logic                  w_sel_write;

    assign w_req        = re | we;
    assign w_sel_addr   = addr[int'(w_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_dout   = dout[int'(w_gnt_idx)*WORD_WIDTH +: WORD_WIDTH];
    // A simultaneous read and write from the winner is executed as a write.
    assign w_sel_write  = |(w_gnt & we);
    assign w_reloc_addr = w_sel_addr + ADDR_WIDTH'(w_gnt_idx) * ADDR_WIDTH'(OFFSET);

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (c_idx_w)
    ) u_arb (
        .req        (w_req),
        .last_grant (r_last_grant),
        .grant      (w_gnt),
        .grant_idx  (w_gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= c_idx_w'(NUM_PORTS - 1);
            r_idx        <= '0;
            r_maddr      <= '0;
            r_mout       <= '0;
            r_mre        <= 1'b0;
            r_mwe        <= 1'b0;
            r_ready      <= '0;
            r_din        <= '0;
`ifdef COMBINE_BOUNDS_EN
            r_err        <= '0;
`endif
        end else begin
            r_ready <= '0;
`ifdef COMBINE_BOUNDS_EN
            r_err   <= '0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_idx <= w_gnt_idx;
`ifdef COMBINE_BOUNDS_EN
                        // Out-of-window requests complete locally, never reaching memory.
                        if (w_sel_addr >= ADDR_WIDTH'(OFFSET)) begin
                            r_ready[w_gnt_idx] <= 1'b1;
                            r_err[w_gnt_idx]   <= 1'b1;
                            r_din[int'(w_gnt_idx)*WORD_WIDTH +: WORD_WIDTH] <= '0;
                            r_last_grant       <= w_gnt_idx;
                            r_state            <= ST_DONE;
                        end else
`endif
                        begin
                            r_maddr <= w_reloc_addr;
                            r_mout  <= w_sel_dout;
                            r_mre   <= ~w_sel_write;
                            r_mwe   <= w_sel_write;
                            r_state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mready) begin
                        r_din[int'(r_idx)*WORD_WIDTH +: WORD_WIDTH] <= min;
                        r_last_grant   <= r_idx;
                        r_ready[r_idx] <= 1'b1;
                        r_mre          <= 1'b0;
                        r_mwe          <= 1'b0;
                        r_state        <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign din   = r_din;
    assign ready = r_ready;
    assign maddr = r_maddr;
    assign mout  = r_mout;
    assign mre   = r_mre;
    assign mwe   = r_mwe;
`ifdef COMBINE_BOUNDS_EN
    assign err   = r_err;
`else
    assign err   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_combine_rr.sv
// ============================================================================
//  Module   : tb_combine_rr
//  Purpose  : Randomised self-checking bench for combine_rr against a
//             transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_combine_rr;

    localparam int N      = 4;
    localparam int AW     = 64;
    localparam int WW     = 64;
    localparam int OFFSET = 128;
`ifdef COMBINE_BOUNDS_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic [N*AW-1:0] addr;
    logic [N*WW-1:0] din;
    logic [N*WW-1:0] dout;
    logic [N-1:0]    re, we, ready, err;
    logic [AW-1:0]   maddr;
    logic [WW-1:0]   mout, min;
    logic            mre, mwe, mready;

    combine_rr #(
        .NUM_PORTS  (N),
        .ADDR_WIDTH (AW),
        .WORD_WIDTH (WW),
        .OFFSET     (OFFSET)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .din    (din),
        .dout   (dout),
        .re     (re),
        .we     (we),
        .ready  (ready),
        .err    (err),
        .maddr  (maddr),
        .mout   (mout),
        .min    (min),
        .mre    (mre),
        .mwe    (mwe),
        .mready (mready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester table
    bit            pend [N];
    bit            p_re [N];
    bit            p_we [N];
    logic [AW-1:0] p_addr [N];
    logic [WW-1:0] p_data [N];

    // Reference model: current phase (0 idle, 1 memory op, 2 completing)
    int            ms, last, cur, wait_cnt, fixed_wait;
    bit            fixed_min_en, refill_all, auto_mode;
    logic [WW-1:0] fixed_min;
    logic [WW-1:0] m_din [N];
    int            grant_log [$];
    logic [AW-1:0] g_maddr;
    logic [WW-1:0] g_mout;
    logic          g_mre, g_mwe;
    logic [N-1:0]  last_err_seen;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int lst, input logic [N-1:0] snap);
        for (int k = 1; k <= N; k++) begin
            int p;
            p = (lst + k) % N;
            if (snap[p]) return p;
        end
        return -1;
    endfunction

    function automatic bit out_of_window(input logic [AW-1:0] a);
        return BOUNDS_EN && (a >= AW'(OFFSET));
    endfunction

    function automatic bit pend_any();
        for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            addr[i*AW +: AW] = p_addr[i];
            dout[i*WW +: WW] = p_data[i];
            re[i]            = pend[i] && p_re[i];
            we[i]            = pend[i] && p_we[i];
        end
    endtask

    task automatic new_req(input int i);
        int op;
        op        = $urandom_range(0, 2);
        p_addr[i] = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom}
                                                : AW'($urandom_range(0, OFFSET - 1));
        p_data[i] = {$urandom, $urandom};
        p_re[i]   = (op != 1);
        p_we[i]   = (op != 0);
        pend[i]   = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [WW-1:0] d,
                           input bit r, input bit w);
        p_addr[i] = a;
        p_data[i] = d;
        p_re[i]   = r;
        p_we[i]   = w;
        pend[i]   = 1'b1;
    endtask

    // One clock: model the edge from what the DUT sampled, check, then drive.
    task automatic step();
        logic [N-1:0]  snap, exp_ready, exp_err;
        bit            rst_seen, mr_seen, exp_re, exp_we;
        logic [WW-1:0] min_seen;
        int            w;
        @(posedge clk);
        for (int i = 0; i < N; i++) snap[i] = pend[i];
        rst_seen = rst;
        mr_seen  = mready;
        min_seen = min;
        #1;
        exp_ready = '0;
        exp_err   = '0;
        if (!rst_seen) begin
            ms   = 0;
            last = N - 1;
            for (int i = 0; i < N; i++) m_din[i] = '0;
            check("rst_maddr", maddr, 64'd0);
            check("rst_mout", mout, 64'd0);
            check("rst_din_zero", {63'd0, |din}, 64'd0);
        end else begin
            case (ms)
                0: if (snap != '0) begin
                    w   = rr_pick(last, snap);
                    cur = w;
                    grant_log.push_back(w);
                    if (out_of_window(p_addr[w])) begin
                        ms           = 2;
                        last         = w;
                        m_din[w]     = '0;
                        exp_ready[w] = 1'b1;
                        exp_err[w]   = 1'b1;
                    end else begin
                        ms       = 1;
                        wait_cnt = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3);
                        g_maddr  = maddr;
                        g_mout   = mout;
                        g_mre    = mre;
                        g_mwe    = mwe;
                    end
                end
                1: if (mr_seen) begin
                    m_din[cur]     = min_seen;
                    last           = cur;
                    ms             = 2;
                    exp_ready[cur] = 1'b1;
                end
                default: ms = 0;
            endcase
        end
        exp_we = (ms == 1) && p_we[cur];
        exp_re = (ms == 1) && p_re[cur] && !p_we[cur];
        check("mre", mre, exp_re);
        check("mwe", mwe, exp_we);
        check("ready", ready, exp_ready);
        check("err", err, exp_err);
        if (ms == 1) begin
            check("maddr", maddr, p_addr[cur] + AW'(cur) * AW'(OFFSET));
            check("mout", mout, p_data[cur]);
        end
        if (exp_ready != '0) begin
            check("din", din[cur*WW +: WW], m_din[cur]);
            last_err_seen = err;
            pend[cur]     = 1'b0;
            if (refill_all || (auto_mode && $urandom_range(0, 1) == 1)) new_req(cur);
        end
        if (auto_mode)
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 5) == 0) new_req(i);
        // Memory responder; mready outside an operation is noise the DUT must ignore.
        if (ms == 1) begin
            if (wait_cnt == 0) begin
                mready = 1'b1;
                min    = fixed_min_en ? fixed_min : {$urandom, $urandom};
            end else begin
                mready = 1'b0;
                wait_cnt--;
            end
        end else begin
            mready = ($urandom_range(0, 3) == 0);
            min    = {$urandom, $urandom};
        end
        drive();
    endtask

    task automatic run_until_idle();
        int n = 0;
        while ((pend_any() || ms != 0) && n < 300) begin
            step();
            n++;
        end
        check("drain_done", {63'd0, (pend_any() || ms != 0)}, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        rst    = 1'b0;
        mready = 1'b0;
        min    = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; p_re[i] = 0; p_we[i] = 0;
            p_addr[i] = '0; p_data[i] = '0; m_din[i] = '0;
        end
        ms = 0; last = N - 1; cur = 0; wait_cnt = 0; fixed_wait = -1;
        fixed_min_en = 0; fixed_min = '0; refill_all = 0; auto_mode = 0;
        last_err_seen = '0;
        drive();
        step();
        step();
        rst = 1'b1;

        // Port 2 read at 5, mready after a delay, returns 0xAB
        set_req(2, 64'd5, 64'h1234, 1'b1, 1'b0);
        fixed_wait = 2; fixed_min_en = 1; fixed_min = 64'hAB;
        drive();
        run_until_idle();
        check("t1_maddr", g_maddr, 64'd261);
        check("t1_mre", {63'd0, g_mre}, 64'd1);
        check("t1_din2", din[2*WW +: WW], 64'hAB);
        fixed_wait = -1; fixed_min_en = 0;

        // Ports 0,1,3 together after reset, then all four continuously
        do_reset();
        grant_log.delete();
        new_req(0); new_req(1); new_req(3);
        drive();
        run_until_idle();
        check("t2_count", grant_log.size(), 64'd3);
        check("t2_first", grant_log[0], 64'd0);
        check("t2_second", grant_log[1], 64'd1);
        check("t2_third", grant_log[2], 64'd3);
        grant_log.delete();
        refill_all = 1;
        for (int i = 0; i < N; i++) new_req(i);
        drive();
        n = 0;
        while (grant_log.size() < 5 && n < 200) begin
            step();
            n++;
        end
        refill_all = 0;
        run_until_idle();
        check("t2b_count_ok", {63'd0, grant_log.size() >= 5}, 64'd1);
        for (int i = 0; i < 5; i++) check("t2b_order", grant_log[i], i % N);

        // Port 1 read+write together is a write
        set_req(1, 64'd7, 64'h55, 1'b1, 1'b1);
        drive();
        run_until_idle();
        check("t3_mwe", {63'd0, g_mwe}, 64'd1);
        check("t3_mre", {63'd0, g_mre}, 64'd0);
        check("t3_mout", g_mout, 64'h55);
        check("t3_maddr", g_maddr, 64'd135);

        // Reset while busy; port 0 must win afterwards
        fixed_wait = 10;
        set_req(3, 64'd9, 64'h77, 1'b1, 1'b0);
        drive();
        n = 0;
        while (ms != 1 && n < 20) begin
            step();
            n++;
        end
        check("t4_busy_reached", ms, 64'd1);
        set_req(0, 64'd3, 64'h99, 1'b1, 1'b0);
        drive();
        rst = 1'b0;
        step();
        check("t4_mre_dropped", {63'd0, mre}, 64'd0);
        rst = 1'b1;
        fixed_wait = -1;
        grant_log.delete();
        run_until_idle();
        check("t4_first_after_rst", grant_log[0], 64'd0);

        // Address outside port 3's window
        set_req(3, 64'd200, 64'h11, 1'b1, 1'b0);
        drive();
        run_until_idle();
`ifdef COMBINE_BOUNDS_EN
        check("t5_err3", {63'd0, last_err_seen[3]}, 64'd1);
        check("t5_din3", din[3*WW +: WW], 64'd0);
`else
        check("t5_maddr", g_maddr, 64'd584);
`endif

        // Randomised traffic with occasional resets
        auto_mode = 1;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 249) != 0);
            step();
        end
        rst = 1'b1;
        auto_mode = 0;
        run_until_idle();
        for (int i = 0; i < N; i++) check("final_din", din[i*WW +: WW], m_din[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
